// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker and its read engine.
package sysid_pkg;

  localparam int TMO_W = 16;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_TS_REQ,
    ST_TS_WAIT,
    ST_DONE
  } sysid_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT
  } rd_state_e;

endpackage

// File: rtl/avm_single_read.sv
// One-outstanding Avalon-MM read engine with per-attempt timeout and bounded retry.
module avm_single_read
  import sysid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        go,
  input  logic        addr,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [31:0] data,
  output logic        data_valid,
  output logic        accept,
  output logic        retry,
  output logic        fail
);

  // Handshake: a request is accepted on a cycle with avm_read=1 and
  // avm_waitrequest=0; read/address hold while stalled, except that an
  // attempt reaching its timeout drops avm_read in that same cycle.
  // Responses count only with avm_readdatavalid=1 while in RD_WAIT.
  rd_state_e        state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       retry_q, retry_d;
  logic             addr_q, addr_d;
  logic             terminal;
  logic             abandon;

  assign terminal    = (state_q != RD_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign data        = avm_readdata;
  assign avm_address = addr_q;

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    addr_d     = addr_q;
    avm_read   = 1'b0;
    data_valid = 1'b0;
    accept     = 1'b0;
    retry      = 1'b0;
    fail       = 1'b0;
    abandon    = 1'b0;
    if (state_q != RD_IDLE) tmo_d = tmo_q + TMO_W'(1);
    case (state_q)
      RD_REQ: begin
        if (terminal) begin
          abandon = 1'b1;
        end else begin
          avm_read = 1'b1;
          if (!avm_waitrequest) begin
            accept  = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // Data in the terminal cycle still counts as a good response.
        if (avm_readdatavalid) begin
          data_valid = 1'b1;
          state_d    = RD_IDLE;
        end else if (terminal) begin
          abandon = 1'b1;
        end
      end
      default: ;
    endcase
    if (abandon) begin
      if (retry_q != 4'd0) begin
        retry   = 1'b1;
        retry_d = retry_q - 4'd1;
        tmo_d   = '0;
        state_d = RD_REQ;
      end else begin
        fail    = 1'b1;
        state_d = RD_IDLE;
      end
    end
    if (go) begin
      state_d = RD_REQ;
      tmo_d   = '0;
      retry_d = 4'(MAX_RETRY);
      addr_d  = addr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RD_IDLE;
      tmo_q   <= '0;
      retry_q <= '0;
      addr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads the system-ID and build-timestamp words after reset or on request
// and reports whether they match the expected constants.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1408812646,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRY      = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e state_q, state_d;
  logic         go, go_addr;
  logic         clr, cap_id, cap_ts, set_tmo;
  logic [31:0]  rd_data;
  logic         rd_valid, rd_accept, rd_retry, rd_fail;

  avm_single_read #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) u_read (
    .clock            (clock),
    .reset_n          (reset_n),
    .go               (go),
    .addr             (go_addr),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .data             (rd_data),
    .data_valid       (rd_valid),
    .accept           (rd_accept),
    .retry            (rd_retry),
    .fail             (rd_fail)
  );

  assign busy = (state_q == ST_ID_REQ) || (state_q == ST_ID_WAIT) ||
                (state_q == ST_TS_REQ) || (state_q == ST_TS_WAIT);
  assign done = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    go_addr = SYSID_ADDR_ID;
    clr     = 1'b0;
    cap_id  = 1'b0;
    cap_ts  = 1'b0;
    set_tmo = 1'b0;
    case (state_q)
      ST_BOOT: begin
        go      = 1'b1;
        state_d = ST_ID_REQ;
      end
      ST_IDLE, ST_DONE: begin
        if (start) begin
          go      = 1'b1;
          clr     = 1'b1;
          state_d = ST_ID_REQ;
        end
      end
      ST_ID_REQ: begin
        if (rd_fail) begin
          set_tmo = 1'b1;
          state_d = ST_DONE;
        end else if (rd_accept) begin
          state_d = ST_ID_WAIT;
        end
      end
      ST_ID_WAIT: begin
        if (rd_valid) begin
          cap_id  = 1'b1;
          go      = 1'b1;
          go_addr = SYSID_ADDR_TS;
          state_d = ST_TS_REQ;
        end else if (rd_fail) begin
          set_tmo = 1'b1;
          state_d = ST_DONE;
        end else if (rd_retry) begin
          state_d = ST_ID_REQ;
        end
      end
      ST_TS_REQ: begin
        if (rd_fail) begin
          set_tmo = 1'b1;
          state_d = ST_DONE;
        end else if (rd_accept) begin
          state_d = ST_TS_WAIT;
        end
      end
      ST_TS_WAIT: begin
        if (rd_valid) begin
          cap_ts  = 1'b1;
          state_d = ST_DONE;
        end else if (rd_fail) begin
          set_tmo = 1'b1;
          state_d = ST_DONE;
        end else if (rd_retry) begin
          state_d = ST_TS_REQ;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BOOT;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (cap_id) begin
        id_value <= rd_data;
        id_ok    <= (rd_data == EXPECTED_ID);
      end
      if (cap_ts) begin
        ts_value <= rd_data;
        ts_ok    <= (rd_data == EXPECTED_TS);
      end
      if (set_tmo) timeout_err <= 1'b1;
    end
  end

endmodule
